// File: rtl/tra_pkg.sv
// Shared types for the traffic phase controller: light codes, states, light decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tra_pkg;

    localparam int PHASE_W = 4;

    localparam logic [1:0] CAR_RED    = 2'b00;
    localparam logic [1:0] CAR_GREEN  = 2'b01;
    localparam logic [1:0] CAR_YELLOW = 2'b10;
    localparam logic [1:0] CAR_LEFT   = 2'b11;

    localparam logic [1:0] HMN_RED    = 2'b00;
    localparam logic [1:0] HMN_GREEN  = 2'b01;
    localparam logic [1:0] HMN_BLINK  = 2'b10;

    // Enum values double as the externally visible phase code.
    typedef enum logic [PHASE_W-1:0] {
        ST_ALL_RED = 4'd0,
        ST_A_GO    = 4'd1,
        ST_A_BLINK = 4'd2,
        ST_A_Y1    = 4'd3,
        ST_A_LEFT  = 4'd4,
        ST_A_Y2    = 4'd5,
        ST_B_GO    = 4'd6,
        ST_B_BLINK = 4'd7,
        ST_B_Y1    = 4'd8,
        ST_B_LEFT  = 4'd9,
        ST_B_Y2    = 4'd10,
        ST_NIGHT   = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] car_a;
        logic [1:0] hmn_a;
        logic [1:0] car_b;
        logic [1:0] hmn_b;
    } lights_t;

    function automatic lights_t light_decode(input state_t st);
        lights_t l;
        l = '{car_a: CAR_RED, hmn_a: HMN_RED, car_b: CAR_RED, hmn_b: HMN_RED};
        case (st)
            ST_A_GO:    begin l.car_a = CAR_GREEN;  l.hmn_b = HMN_GREEN; end
            ST_A_BLINK: begin l.car_a = CAR_GREEN;  l.hmn_b = HMN_BLINK; end
            ST_A_Y1,
            ST_A_Y2:    l.car_a = CAR_YELLOW;
            ST_A_LEFT:  l.car_a = CAR_LEFT;
            ST_B_GO:    begin l.car_b = CAR_GREEN;  l.hmn_a = HMN_GREEN; end
            ST_B_BLINK: begin l.car_b = CAR_GREEN;  l.hmn_a = HMN_BLINK; end
            ST_B_Y1,
            ST_B_Y2:    l.car_b = CAR_YELLOW;
            ST_B_LEFT:  l.car_b = CAR_LEFT;
            ST_NIGHT:   begin l.car_a = CAR_YELLOW; l.car_b = CAR_YELLOW; end
            default:    ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tra_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clk cycles, restartable via clr.
// Latency: tick is a decode of the count register (same cycle).
// Backpressure: none, free-running.
module tra_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] cnt_q;

    assign tick = (cnt_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PW'(1);
        end
    end

endmodule

// File: rtl/tra_phase_ctrl.sv
// Two-direction traffic light sequencer with left-turn phases and night flashing.
// Latency: lights/phase registered with the state; phase_done marks the last clk of a phase.
// Backpressure: none, free-running timer.
module tra_phase_ctrl
    import tra_pkg::*;
#(
    parameter int GO_T     = 14,
    parameter int BLINK_T  = 6,
    parameter int YEL_T    = 2,
    parameter int LEFT_T   = 10,
    parameter int LEFT_EN  = 1,
    parameter int ALLRED_T = 1,
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               night_mode,
    output logic [1:0]         car_light_a,
    output logic [1:0]         car_light_b,
    output logic [1:0]         hmn_light_a,
    output logic [1:0]         hmn_light_b,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_done
);

    localparam longint MAX_D = longint'(1) << CNT_W;

    if (GO_T < 1 || BLINK_T < 1 || YEL_T < 1 || LEFT_T < 1 || ALLRED_T < 1 ||
        GO_T > MAX_D || BLINK_T > MAX_D || YEL_T > MAX_D || LEFT_T > MAX_D ||
        ALLRED_T > MAX_D || TICK_DIV < 1) begin : g_param_chk
        $fatal(1, "tra_phase_ctrl: illegal timing parameters");
    end

    state_t           state_q;
    state_t           nxt_st;
    lights_t          lights_q;
    logic [CNT_W-1:0] timer_q;
    logic             tick;
    logic             phase_end;

    function automatic logic [CNT_W-1:0] dur_m1(input state_t st);
        case (st)
            ST_ALL_RED:            return CNT_W'(ALLRED_T - 1);
            ST_A_GO,   ST_B_GO:    return CNT_W'(GO_T - 1);
            ST_A_BLINK, ST_B_BLINK: return CNT_W'(BLINK_T - 1);
            ST_A_LEFT, ST_B_LEFT:  return CNT_W'(LEFT_T - 1);
            ST_NIGHT:              return '0;
            default:               return CNT_W'(YEL_T - 1);
        endcase
    endfunction

    function automatic state_t succ(input state_t st);
        case (st)
            ST_ALL_RED: return ST_A_GO;
            ST_A_GO:    return ST_A_BLINK;
            ST_A_BLINK: return ST_A_Y1;
            ST_A_Y1:    return (LEFT_EN != 0) ? ST_A_LEFT : ST_B_GO;
            ST_A_LEFT:  return ST_A_Y2;
            ST_A_Y2:    return ST_B_GO;
            ST_B_GO:    return ST_B_BLINK;
            ST_B_BLINK: return ST_B_Y1;
            ST_B_Y1:    return (LEFT_EN != 0) ? ST_B_LEFT : ST_ALL_RED;
            ST_B_LEFT:  return ST_B_Y2;
            default:    return ST_ALL_RED;
        endcase
    endfunction

    tra_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_end),
        .tick  (tick)
    );

    // NIGHT has no timer: it ends on any tick once the request is withdrawn.
    assign phase_end = tick && ((state_q == ST_NIGHT) ? !night_mode : (timer_q == '0));

    always_comb begin
        nxt_st = ST_ALL_RED;
        if (state_q != ST_NIGHT) begin
            nxt_st = night_mode ? ST_NIGHT : succ(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ALL_RED;
            lights_q <= '0;
            timer_q  <= CNT_W'(ALLRED_T - 1);
        end else if (phase_end) begin
            state_q  <= nxt_st;
            lights_q <= light_decode(nxt_st);
            timer_q  <= dur_m1(nxt_st);
        end else if (tick && state_q != ST_NIGHT) begin
            timer_q  <= timer_q - CNT_W'(1);
        end
    end

    assign car_light_a = lights_q.car_a;
    assign hmn_light_a = lights_q.hmn_a;
    assign car_light_b = lights_q.car_b;
    assign hmn_light_b = lights_q.hmn_b;
    assign phase       = state_q;
    // Gated so the pulse stays low while the block is held in reset.
    assign phase_done  = rst_n && phase_end;

endmodule

// File: tb/tb_tra_phase_ctrl.sv
// Directed bench for tra_phase_ctrl: default, no-left-turn and divided-tick variants.
module tb_tra_phase_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic night_mode = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] ca_d, cb_d, ha_d, hb_d, ca_n, cb_n, ha_n, hb_n, ca_v, cb_v, ha_v, hb_v;
    logic [3:0] ph_d, ph_n, ph_v;
    logic       pd_d, pd_n, pd_v;

    tra_phase_ctrl u_def (
        .clk(clk), .rst_n(rst_n), .night_mode(night_mode),
        .car_light_a(ca_d), .car_light_b(cb_d), .hmn_light_a(ha_d), .hmn_light_b(hb_d),
        .phase(ph_d), .phase_done(pd_d)
    );

    tra_phase_ctrl #(.LEFT_EN(0)) u_nl (
        .clk(clk), .rst_n(rst_n), .night_mode(night_mode),
        .car_light_a(ca_n), .car_light_b(cb_n), .hmn_light_a(ha_n), .hmn_light_b(hb_n),
        .phase(ph_n), .phase_done(pd_n)
    );

    tra_phase_ctrl #(.TICK_DIV(4)) u_div (
        .clk(clk), .rst_n(rst_n), .night_mode(night_mode),
        .car_light_a(ca_v), .car_light_b(cb_v), .hmn_light_a(ha_v), .hmn_light_b(hb_v),
        .phase(ph_v), .phase_done(pd_v)
    );

    // Observed vector layout: {phase, car_a, hmn_a, car_b, hmn_b, phase_done}
    logic [12:0] v_def, v_nl, v_div;
    assign v_def = {ph_d, ca_d, ha_d, cb_d, hb_d, pd_d};
    assign v_nl  = {ph_n, ca_n, ha_n, cb_n, hb_n, pd_n};
    assign v_div = {ph_v, ca_v, ha_v, cb_v, hb_v, pd_v};

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Light pattern {car_a, hmn_a, car_b, hmn_b} per phase code
    function automatic logic [7:0] lights_of(input int code);
        case (code)
            1:       return 8'b01_00_00_01;
            2:       return 8'b01_00_00_10;
            3, 5:    return 8'b10_00_00_00;
            4:       return 8'b11_00_00_00;
            6:       return 8'b00_01_01_00;
            7:       return 8'b00_10_01_00;
            8, 10:   return 8'b00_00_10_00;
            9:       return 8'b00_00_11_00;
            11:      return 8'b10_00_10_00;
            default: return 8'b00_00_00_00;
        endcase
    endfunction

    // Expected vector k cycles after reset release, with no night request.
    function automatic logic [12:0] exp_vec(input int le, input int k, input int div);
        int durs [11];
        int per, t, code;
        logic done;
        durs = '{1, 14, 6, 2, 10, 2, 14, 6, 2, 10, 2};
        per = 0;
        for (int i = 0; i < 11; i++)
            if (le != 0 || !(i == 4 || i == 5 || i == 9 || i == 10)) per += durs[i] * div;
        t = k % per;
        code = 0;
        done = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (le == 0 && (i == 4 || i == 5 || i == 9 || i == 10)) continue;
            if (t < durs[i] * div) begin
                code = i;
                done = (t == durs[i] * div - 1);
                break;
            end
            t -= durs[i] * div;
        end
        return {4'(code), lights_of(code), done};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        night_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_def", v_def, 13'h0);
        check_eq("rst_nl",  v_nl,  13'h0);
        check_eq("rst_div", v_div, 13'h0);
        rst_n = 1'b1;
        #1;
    endtask

    localparam logic [12:0] NIGHT_V = {4'd11, 8'b10_00_10_00, 1'b0};

    initial begin
        // Normal sequencing on all three variants
        do_reset();
        for (int k = 0; k <= 276; k++) begin
            if (k > 0) step();
            if (k <= 138) check_eq($sformatf("def_k%0d", k), v_def, exp_vec(1, k, 1));
            if (k <= 90)  check_eq($sformatf("nl_k%0d", k),  v_nl,  exp_vec(0, k, 1));
            check_eq($sformatf("div_k%0d", k), v_div, exp_vec(1, k, 4));
        end

        // Short request inside A_GO, gone before the phase end: no NIGHT
        do_reset();
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) step();
            night_mode = (k >= 5 && k <= 7);
            check_eq($sformatf("pulse_k%0d", k), v_def, exp_vec(1, k, 1));
        end
        night_mode = 1'b0;

        // Request held across the end of A_GO: NIGHT replaces A_BLINK
        do_reset();
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) step();
            if (k == 10) night_mode = 1'b1;
            check_eq($sformatf("hold_k%0d", k), v_def, exp_vec(1, k, 1));
        end
        for (int k = 15; k <= 18; k++) begin
            step();
            check_eq($sformatf("night_k%0d", k), v_def, NIGHT_V);
        end
        night_mode = 1'b0;
        #1;
        check_eq("night_exit_done", v_def, NIGHT_V | 13'h1);
        step();
        check_eq("after_night_allred", v_def, {4'd0, 8'h00, 1'b1});
        step();
        check_eq("after_night_ago", v_def, {4'd1, 8'b01_00_00_01, 1'b0});

        // Asynchronous reset in the middle of B_LEFT
        do_reset();
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) step();
            if (k == 60) check_eq("pre_rst_bleft", v_def, exp_vec(1, k, 1));
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_def", v_def, 13'h0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            check_eq($sformatf("restart_k%0d", k), v_def, exp_vec(1, k, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tra_phase_ctrl.md
TRA_PHASE_CTRL -- requirements
Module: tra_phase_ctrl

Interface
REQ-001 Parameter GO_T, default 14, car-green and pedestrian-steady ticks per direction.
REQ-002 Parameter BLINK_T, default 6, car-green and pedestrian-blink ticks.
REQ-003 Parameter YEL_T, default 2, ticks for each yellow phase.
REQ-004 Parameter LEFT_T, default 10, left-arrow ticks.
REQ-005 Parameter LEFT_EN, default 1, enables the left-turn and second-yellow phases (0 removes them).
REQ-006 Parameter ALLRED_T, default 1, all-red ticks at the start of each cycle.
REQ-007 Parameter TICK_DIV, default 1, clk cycles per timing tick.
REQ-008 Parameter CNT_W, default 8, width of the phase timer.
REQ-009 clk  in  1  single clock, rising edge.
REQ-010 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-011 night_mode  in  1  request to enter or stay in night flashing mode.
REQ-012 car_light_a / car_light_b  out  2  car signals: 00 red, 01 green, 10 yellow, 11 left.
REQ-013 hmn_light_a / hmn_light_b  out  2  pedestrian signals: 00 red, 01 green, 10 blink.
REQ-014 phase  out  4  current state code.
REQ-015 phase_done  out  1  one-cycle pulse in the last clk of each phase.

Function
REQ-016 States SHALL be ALL_RED, A_GO, A_BLINK, A_Y1, A_LEFT, A_Y2, B_GO, B_BLINK, B_Y1, B_LEFT, B_Y2, NIGHT, with phase codes 0 to 11 in that order.
REQ-017 The normal sequence SHALL be ALL_RED, then the A states in listed order, then the B states in listed order, then back to ALL_RED.
REQ-018 When LEFT_EN=0, A_Y1 SHALL go directly to B_GO and B_Y1 SHALL go directly to ALL_RED.
REQ-019 Each state SHALL last exactly its parameter value in ticks; NIGHT is untimed.
REQ-020 A tick SHALL occur once every TICK_DIV clk cycles; with TICK_DIV=1 every cycle is a tick.
REQ-021 The timer SHALL load duration-1 on phase entry and decrement on each tick; the phase ends on a tick with timer = 0.
REQ-022 Outputs SHALL be a Moore decode of the state register, with no combinational path from night_mode.
REQ-023 In ALL_RED, all four outputs SHALL be 00.
REQ-024 In A_GO, car_a SHALL be green, hmn_a red, car_b red and hmn_b green.
REQ-025 In A_BLINK, outputs SHALL match A_GO except hmn_b = blink.
REQ-026 In A_Y1 and A_Y2, car_a SHALL be yellow; in A_LEFT, car_a SHALL be left; in all three, the other outputs SHALL be red.
REQ-027 The B states SHALL mirror the A states with a and b swapped.
REQ-028 In NIGHT, car_a and car_b SHALL be yellow and hmn_a and hmn_b SHALL be red.
REQ-029 night_mode SHALL be sampled only at a phase end; if it is 1, the next state is NIGHT instead of the normal successor.
REQ-030 NIGHT SHALL exit to ALL_RED on the first tick where night_mode=0, and the timer and prescaler SHALL restart.
REQ-031 phase_done SHALL pulse at every phase end, including the NIGHT exit.
REQ-032 The full period SHALL be ALL_RED plus two times the direction time, where direction time = GO + BLINK + YEL + LEFT_EN × (LEFT + YEL); with defaults this is 69 ticks.
REQ-033 Elaboration SHALL fail if any duration is below 1, any duration exceeds 2^CNT_W, or TICK_DIV is below 1.

Reset
REQ-034 While rst_n=0, the block SHALL be asynchronously placed in ALL_RED, with timer = ALLRED_T-1, prescaler 0, all lights 00 and phase_done 0.
REQ-035 Reset asserted mid-phase, including in NIGHT, SHALL abandon that phase immediately.
REQ-036 With TICK_DIV=1, the first clk edge after reset release SHALL end ALL_RED, so A_GO is active in cycles 1 to 14.

Structure
REQ-037 Package tra_pkg SHALL hold the light encodings, the state enumeration and the phase codes.
REQ-038 Sub-module tra_tick_gen SHALL be the TICK_DIV prescaler that produces a one-cycle tick pulse.

Verification
REQ-039 Defaults, night_mode=0, run 138 cycles: outputs SHALL match the 69-cycle table twice (cycle 14 A_GO; cycle 15 A_BLINK with hmn_b=10; cycles 57–66 car_b=11).
REQ-040 LEFT_EN=0: the period SHALL be 45 ticks, and the state after A_Y1 SHALL be B_GO.
REQ-041 TICK_DIV=4: A_GO SHALL last 56 clk cycles, and phase_done SHALL be asserted for one cycle only.
REQ-042 night_mode=1 pulsed mid-A_GO then dropped: there SHALL be no NIGHT entry (sampled only at phase end); held across the end of A_GO: A_BLINK is skipped and NIGHT is entered with both car lights at 10; on release, the next state SHALL be ALL_RED.
REQ-043 rst_n dropped asynchronously mid-B_LEFT: outputs SHALL be 00 immediately; after release, the sequence SHALL restart with A_GO in cycles 1 to 14.
